// File: rtl/lsu_ram_ctrl_if.sv
// Core-side load/store request and response bundle for lsu_ram_ctrl.
// The master drives requests (memory stage) and the slave returns responses (controller).
interface lsu_ram_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_fn;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_fn, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_fn, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_ram_ctrl.sv
// RV32I load/store sequencer for a single-port, synchronous-read data RAM without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-selected and sign/zero extended.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// RD_ADDR | word address on the RAM, read in flight
// RD_DATA | ram_q valid: extend load data or merge sub-word store
// WRITE   | ram_wren pulse with the final word
// RESP    | rsp_valid pulse (data, store ack or error)
module lsu_ram_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_ram_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        fn_q, fn_d;
    logic [1:0]        addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [31:0]       ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;

    logic              req_bad;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    always_comb begin
        unique case (bus.req_fn)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = bus.req_addr[0];
            3'b010:         req_bad = |bus.req_addr[1:0];
            default:        req_bad = 1'b1;
        endcase
        // BU/HU have no store counterpart
        if (bus.req_we && bus.req_fn[2]) req_bad = 1'b1;
    end

    always_comb begin
        lane_b = ram_q[{addr_q, 3'b000} +: 8];
        lane_h = ram_q[{addr_q[1], 4'b0000} +: 16];
        unique case (fn_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h0, lane_b};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = ram_q;
        endcase
    end

    always_comb begin
        merged = ram_q;
        if (fn_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        else         merged[{addr_q, 3'b000} +: 8]      = wdata_q[7:0];
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        fn_d          = fn_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    fn_d    = bus.req_fn;
                    addr_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata[15:0];
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else if (bus.req_we && bus.req_fn == 3'b010) begin
                        state_d       = WRITE;
                        ram_address_d = bus.req_addr[ADDR_W+1:2];
                        ram_data_d    = bus.req_wdata;
                        ram_wren_d    = 1'b1;
                    end else begin
                        state_d       = RD_ADDR;
                        ram_address_d = bus.req_addr[ADDR_W+1:2];
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                if (we_q) begin
                    state_d    = WRITE;
                    ram_data_d = merged;
                    ram_wren_d = 1'b1;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_ext;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            fn_q          <= 3'b000;
            addr_q        <= 2'b00;
            wdata_q       <= 16'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= 32'h0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            fn_q          <= fn_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign ram_address   = ram_address_q;
    assign ram_data      = ram_data_q;
    assign ram_wren      = ram_wren_q;
endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Self-checking bench for lsu_ram_ctrl: behavioural RAM, reference memory model and response scoreboard.
module tb_lsu_ram_ctrl;
    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsu_ram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic [31:0]       ram_q;

    lsu_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    logic [31:0] ram_mem [0:2047];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    typedef struct packed {
        logic        we;
        logic [2:0]  fn;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int          n_checks = 0;
    int          n_pass = 0;
    int          wr_cnt = 0;
    int          rsp_cnt = 0;
    logic        prev_wren = 1'b0;
    logic [10:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    rsp_t        sbq[$];
    rsp_t        exp_r;
    logic [31:0] mdl [0:2047];
    vec_t        tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference behaviour: returns the expected response and updates the model memory for stores.
    task automatic mdl_req(input logic we, input logic [2:0] fn, input logic [12:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        case (fn)
            3'b000, 3'b100: er = 1'b0;
            3'b001, 3'b101: er = addr[0];
            3'b010:         er = (addr[1:0] != 2'b00);
            default:        er = 1'b1;
        endcase
        if (we && (fn == 3'b100 || fn == 3'b101)) er = 1'b1;
        w  = mdl[addr[12:2]];
        b  = 8'(w >> (8 * addr[1:0]));
        h  = 16'(w >> (16 * addr[1]));
        rd = 32'h0;
        if (!er) begin
            if (we) begin
                case (fn)
                    3'b000:  w[8*addr[1:0] +: 8] = wd[7:0];
                    3'b001:  w[16*addr[1] +: 16] = wd[15:0];
                    default: w = wd;
                endcase
                mdl[addr[12:2]] = w;
            end else begin
                case (fn)
                    3'b000:  rd = {{24{b[7]}}, b};
                    3'b001:  rd = {{16{h[15]}}, h};
                    3'b100:  rd = {24'h0, b};
                    3'b101:  rd = {16'h0, h};
                    default: rd = w;
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wren) begin
                wr_cnt++;
                last_wr_addr = ram_address;
                last_wr_data = ram_data;
                chk("wren_single", {31'h0, prev_wren}, 32'h0);
            end
            prev_wren = ram_wren;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 with no request outstanding");
                end else begin
                    exp_r = sbq.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, exp_r.rdata);
                    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, exp_r.err});
                end
            end
        end else begin
            prev_wren = 1'b0;
        end
    end

    task automatic issue(input vec_t v);
        logic [31:0] mrd;
        logic        mer;
        int          lat, exp_lat, w0, t;
        mdl_req(v.we, v.fn, v.addr, v.wdata, mrd, mer);
        exp_lat = v.exp_err ? 1 : (!v.we ? 3 : (v.fn == 3'b010 ? 2 : 4));
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_fn    = v.fn;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", t);
            bus.req_valid = 1'b0;
            return;
        end
        sbq.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        w0 = wr_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("write_count", 32'(wr_cnt - w0), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        if (v.we && !v.exp_err) begin
            chk("wr_addr", {21'h0, last_wr_addr}, {21'h0, v.addr[12:2]});
            chk("wr_data", last_wr_data, mdl[v.addr[12:2]]);
        end
        @(negedge clk);
        chk("ready_back", {31'h0, bus.req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ready"},  {31'h0, bus.req_ready}, 32'd1);
        chk({nm, "_valid"},  {31'h0, bus.rsp_valid}, 32'd0);
        chk({nm, "_err"},    {31'h0, bus.rsp_err},   32'd0);
        chk({nm, "_rdata"},  bus.rsp_rdata,          32'd0);
        chk({nm, "_addr"},   {21'h0, ram_address},   32'd0);
        chk({nm, "_wdata"},  ram_data,               32'd0);
        chk({nm, "_wren"},   {31'h0, ram_wren},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] mrd;
        logic        mer;
        int          w0, r0, t, n;
        vec_t        v;

        tbl[0]  = '{1'b1, 3'b010, 13'h0010, 32'hA1B2C3D4, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 3'b010, 13'h0010, 32'h0,        32'hA1B2C3D4, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 13'h0013, 32'h0,        32'hFFFFFFA1, 1'b0};
        tbl[3]  = '{1'b0, 3'b100, 13'h0013, 32'h0,        32'h000000A1, 1'b0};
        tbl[4]  = '{1'b0, 3'b001, 13'h0012, 32'h0,        32'hFFFFA1B2, 1'b0};
        tbl[5]  = '{1'b0, 3'b101, 13'h0010, 32'h0,        32'h0000C3D4, 1'b0};
        tbl[6]  = '{1'b0, 3'b000, 13'h0010, 32'h0,        32'hFFFFFFD4, 1'b0};
        tbl[7]  = '{1'b1, 3'b000, 13'h0011, 32'hDEADBE5A, 32'h00000000, 1'b0};
        tbl[8]  = '{1'b0, 3'b010, 13'h0010, 32'h0,        32'hA1B25AD4, 1'b0};
        tbl[9]  = '{1'b1, 3'b001, 13'h0012, 32'hFFFF1234, 32'h00000000, 1'b0};
        tbl[10] = '{1'b0, 3'b010, 13'h0010, 32'h0,        32'h12345AD4, 1'b0};
        tbl[11] = '{1'b0, 3'b010, 13'h0012, 32'h0,        32'h00000000, 1'b1};
        tbl[12] = '{1'b1, 3'b001, 13'h0011, 32'h0000FFFF, 32'h00000000, 1'b1};
        tbl[13] = '{1'b0, 3'b011, 13'h0010, 32'h0,        32'h00000000, 1'b1};
        tbl[14] = '{1'b1, 3'b100, 13'h0010, 32'h000000EE, 32'h00000000, 1'b1};
        tbl[15] = '{1'b0, 3'b010, 13'h0010, 32'h0,        32'h12345AD4, 1'b0};
        tbl[16] = '{1'b1, 3'b010, 13'h1FFC, 32'hCAFEBEEF, 32'h00000000, 1'b0};
        tbl[17] = '{1'b0, 3'b101, 13'h1FFE, 32'h0,        32'h0000CAFE, 1'b0};

        for (int i = 0; i < 2048; i++) mdl[i] = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_fn    = 3'b000;
        bus.req_addr  = '0;
        bus.req_wdata = 32'h0;

        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) issue(tbl[i]);

        // Abort a sub-word store mid read-modify-write with an asynchronous reset.
        v = '{1'b1, 3'b010, 13'h0010, 32'hA1B2C3D4, 32'h00000000, 1'b0};
        issue(v);
        v = '{1'b0, 3'b010, 13'h0010, 32'h0, 32'hA1B2C3D4, 1'b0};
        issue(v);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_fn    = 3'b000;
        bus.req_addr  = 13'h0011;
        bus.req_wdata = 32'h0000005A;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        w0 = wr_cnt;
        r0 = rsp_cnt;
        rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        chk("abort_ram_word", ram_mem[4], 32'hA1B2C3D4);
        v = '{1'b0, 3'b010, 13'h0010, 32'h0, 32'hA1B2C3D4, 1'b0};
        issue(v);

        // Back-to-back stream with req_valid held high: SW then LW per word.
        r0 = rsp_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_we    = (i % 2 == 0);
            bus.req_fn    = 3'b010;
            bus.req_addr  = 13'((i / 2) * 4);
            bus.req_wdata = $urandom;
            t = 0;
            while (!bus.req_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!bus.req_ready) begin
                n_checks++;
                $display("FAIL stream_accept_timeout: req_ready=0, required 1");
                break;
            end
            mdl_req(bus.req_we, bus.req_fn, bus.req_addr, bus.req_wdata, mrd, mer);
            sbq.push_back('{rdata: mrd, err: mer});
            @(posedge clk);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.req_ready && n < 20);
            chk("stream_ready_gap", 32'(n), (i % 2 == 0) ? 32'd3 : 32'd4);
        end
        bus.req_valid = 1'b0;
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("stream_rsp_count", 32'(rsp_cnt - r0), 32'd8);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
